// File: rtl/interrupt_controller_pkg.sv
// Shared CPU package for the interrupt controller: FSM encodings and default constants.
package interrupt_controller_pkg;

    localparam int unsigned MAX_SRC = 16;
    localparam int unsigned IDX_W   = 4;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StReq     = 2'd1;
    localparam logic [1:0] StService = 2'd2;

    localparam logic [15:0] DEFAULT_VECTOR_BASE  = 16'h0010;
    localparam logic [3:0]  DEFAULT_MASK_IO_ADDR = 4'hF;

endpackage

// File: rtl/interrupt_controller_if.sv
// Device request lines plus control-unit io_* strobes for the interrupt controller.
interface interrupt_controller_if #(
    parameter int unsigned NUM_SRC = interrupt_controller_pkg::MAX_SRC
);

    logic [NUM_SRC-1:0] irq_in;
    logic [NUM_SRC-1:0] irq_ack;
    logic               io_interrupt;
    logic               io_store_retaddr;
    logic               io_push_int_addr;
    logic               io_push_retaddr;
    logic               io_push_ints;
    logic               io_write;
    logic [3:0]         io_addr;
    logic [15:0]        pc_value;

    modport slave (
        input  irq_in,
        input  io_store_retaddr,
        input  io_push_int_addr,
        input  io_push_retaddr,
        input  io_push_ints,
        input  io_write,
        input  io_addr,
        input  pc_value,
        output irq_ack,
        output io_interrupt
    );

    modport master (
        output irq_in,
        output io_store_retaddr,
        output io_push_int_addr,
        output io_push_retaddr,
        output io_push_ints,
        output io_write,
        output io_addr,
        output pc_value,
        input  irq_ack,
        input  io_interrupt
    );

endinterface

// File: rtl/interrupt_controller_rr_priority_pick.sv
// Combinational round-robin picker: first set bit of eligible_i at or after start_i, wrapping.
module rr_priority_pick
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned N = MAX_SRC
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] index_o
);

    logic [MAX_SRC-1:0] elig_pad;
    logic [IDX_W:0]     idx;

    // Scan from the farthest offset down so the nearest eligible index is written last.
    always_comb begin
        found_o  = 1'b0;
        index_o  = '0;
        idx      = '0;
        elig_pad = '0;
        elig_pad[N-1:0] = eligible_i;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = {1'b0, start_i} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(N)) begin
                idx = idx - (IDX_W+1)'(N);
            end
            if (elig_pad[idx[IDX_W-1:0]]) begin
                found_o = 1'b1;
                index_o = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Round-robin interrupt arbiter and sequencing slave between IO devices and the control unit.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned NUM_SRC      = MAX_SRC,
    parameter logic [15:0] VECTOR_BASE  = DEFAULT_VECTOR_BASE,
    parameter logic [3:0]  MASK_IO_ADDR = DEFAULT_MASK_IO_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    interrupt_controller_if.slave bus,
    inout  wire  [15:0]           d_bus
);

    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic [NUM_SRC-1:0] rise, clr, eligible;
    logic [15:0]        mask_q, mask_d;
    logic [15:0]        ret_addr_q, ret_addr_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   pick_index;
    logic [1:0]         state_q, state_d;
    logic               pick_found;
    logic [15:0]        vector;
    logic [15:0]        drive_val;
    logic               drive_en;

    assign rise     = bus.irq_in & ~irq_q;
    assign eligible = pending_q & mask_q[NUM_SRC-1:0];
    assign vector   = VECTOR_BASE + {{(16-IDX_W){1'b0}}, grant_q};

    rr_priority_pick #(
        .N (NUM_SRC)
    ) u_pick (
        .eligible_i (eligible),
        .start_i    (rr_ptr_q),
        .found_o    (pick_found),
        .index_o    (pick_index)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        ret_addr_d = ret_addr_q;
        clr        = '0;
        ack_d      = '0;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_index;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.io_store_retaddr) begin
                    ret_addr_d     = bus.pc_value;
                    clr[grant_q]   = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    rr_ptr_d       = (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
                    state_d        = StService;
                end
            end
            StService: begin
                if (bus.io_push_retaddr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A new edge in the same cycle as the acceptance clear keeps the bit pending.
    assign pending_d = (pending_q & ~clr) | rise;
    assign mask_d    = (bus.io_write && (bus.io_addr == MASK_IO_ADDR)) ? d_bus : mask_q;

    always_comb begin
        drive_en  = 1'b1;
        drive_val = '0;
        if (bus.io_push_int_addr) begin
            drive_val = vector;
        end else if (bus.io_push_retaddr) begin
            drive_val = ret_addr_q;
        end else if (bus.io_push_ints) begin
            drive_val[NUM_SRC-1:0] = pending_q;
        end else begin
            drive_en = 1'b0;
        end
    end

    assign d_bus            = drive_en ? drive_val : 16'hzzzz;
    assign bus.io_interrupt = (state_q == StReq);
    assign bus.irq_ack      = ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            irq_q      <= '0;
            pending_q  <= '0;
            ack_q      <= '0;
            mask_q     <= 16'hFFFF;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            ret_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            irq_q      <= bus.irq_in;
            pending_q  <= pending_d;
            ack_q      <= ack_d;
            mask_q     <= mask_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            ret_addr_q <= ret_addr_d;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed plus randomized bench for interrupt_controller against a transaction-level model.
module tb_interrupt_controller;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    interrupt_controller_if #(.NUM_SRC(N)) bus_if ();

    wire  [15:0] d_bus;
    logic        tb_en;
    logic [15:0] tb_val;
    assign d_bus = tb_en ? tb_val : 16'hzzzz;

    interrupt_controller #(
        .NUM_SRC      (N),
        .VECTOR_BASE  (16'h0010),
        .MASK_IO_ADDR (4'hF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_if),
        .d_bus (d_bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = waiting, 1 = requesting, 2 = in service.
    logic [15:0] m_pending, m_prev, m_mask, m_ret, m_ack;
    int          m_rr, m_grant, m_state;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pending = '0; m_prev = '0; m_mask = 16'hFFFF; m_ret = '0; m_ack = '0;
        m_rr = 0; m_grant = 0; m_state = 0;
    endtask

    task automatic check_outputs();
        logic [15:0] exp_bus;
        bit          chk_bus;
        check("io_interrupt", {15'd0, bus_if.io_interrupt}, {15'd0, (m_state == 1)});
        check("irq_ack", bus_if.irq_ack, m_ack);
        chk_bus = 1'b1;
        exp_bus = '0;
        if (bus_if.io_push_int_addr)     exp_bus = 16'h0010 + 16'(m_grant);
        else if (bus_if.io_push_retaddr) exp_bus = m_ret;
        else if (bus_if.io_push_ints)    exp_bus = m_pending;
        else if (tb_en)                  exp_bus = tb_val;
        else                             chk_bus = 1'b0;
        if (chk_bus) check("d_bus", d_bus, exp_bus);
    endtask

    task automatic settle();
        tb_en = !(bus_if.io_push_int_addr || bus_if.io_push_retaddr || bus_if.io_push_ints);
        if (!bus_if.io_write) tb_val = 16'($urandom);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic tick();
        logic [15:0] rise, clr, elig;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            rise = bus_if.irq_in & ~m_prev;
            clr  = '0;
            elig = m_pending & m_mask;
            if (m_state == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (elig[(m_rr + k) % N]) begin
                        m_grant = (m_rr + k) % N;
                        m_state = 1;
                        break;
                    end
                end
            end else if (m_state == 1) begin
                if (bus_if.io_store_retaddr) begin
                    m_ret   = bus_if.pc_value;
                    clr     = 16'(32'd1 << m_grant);
                    m_rr    = (m_grant + 1) % N;
                    m_state = 2;
                end
            end else if (bus_if.io_push_retaddr) begin
                m_state = 0;
            end
            if (bus_if.io_write && bus_if.io_addr == 4'hF) m_mask = tb_val;
            m_pending = (m_pending & ~clr) | rise;
            m_prev    = bus_if.irq_in;
            m_ack     = clr;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic clr_in();
        bus_if.irq_in = '0;
        bus_if.io_store_retaddr = 1'b0;
        bus_if.io_push_int_addr = 1'b0;
        bus_if.io_push_retaddr = 1'b0;
        bus_if.io_push_ints = 1'b0;
        bus_if.io_write = 1'b0;
        bus_if.io_addr = 4'h0;
        bus_if.pc_value = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic pulse(input int src);
        bus_if.irq_in = 16'(32'd1 << src);
        cyc();
        bus_if.irq_in = '0;
        cyc();
    endtask

    task automatic write_mask(input logic [15:0] val);
        bus_if.io_write = 1'b1;
        bus_if.io_addr  = 4'hF;
        tb_val = val;
        cyc();
        bus_if.io_write = 1'b0;
    endtask

    task automatic accept(input int src, input logic [15:0] pc, input string tag);
        int waited = 0;
        settle();
        while (bus_if.io_interrupt !== 1'b1 && waited < 8) begin
            tick();
            settle();
            waited++;
        end
        check({tag, "_int"}, {15'd0, bus_if.io_interrupt}, 16'd1);
        tick();
        bus_if.io_push_int_addr = 1'b1;
        settle();
        check({tag, "_vec"}, d_bus, 16'h0010 + 16'(src));
        tick();
        bus_if.io_push_int_addr = 1'b0;
        bus_if.pc_value = pc;
        bus_if.io_store_retaddr = 1'b1;
        cyc();
        bus_if.io_store_retaddr = 1'b0;
        settle();
        check({tag, "_ack"}, bus_if.irq_ack, 16'(32'd1 << src));
        tick();
    endtask

    task automatic serve(input int src, input logic [15:0] pc, input string tag);
        accept(src, pc, tag);
        bus_if.io_push_retaddr = 1'b1;
        settle();
        check({tag, "_ret"}, d_bus, pc);
        tick();
        bus_if.io_push_retaddr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic any_push;
        clr_in();
        tb_en  = 1'b1;
        tb_val = '0;
        rst    = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        settle();
        check("rst_int", {15'd0, bus_if.io_interrupt}, 16'd0);
        check("rst_ack", bus_if.irq_ack, 16'd0);
        check("rst_bus_released", d_bus, tb_val);
        tick();

        // Single request with latency
        bus_if.irq_in = 16'h0008;
        cyc();
        bus_if.irq_in = '0;
        settle();
        check("lat_n1", {15'd0, bus_if.io_interrupt}, 16'd0);
        tick();
        settle();
        check("lat_n2", {15'd0, bus_if.io_interrupt}, 16'd1);
        tick();
        serve(3, 16'h0123, "single");
        settle();
        check("single_idle", {15'd0, bus_if.io_interrupt}, 16'd0);
        tick();

        // Round-robin ordering
        do_reset();
        bus_if.irq_in = 16'h0024;
        cyc();
        bus_if.irq_in = '0;
        serve(2, 16'h1111, "rr_a");
        serve(5, 16'h2222, "rr_b");
        bus_if.irq_in = 16'h0006;
        cyc();
        bus_if.irq_in = '0;
        serve(1, 16'h3333, "rr_c");
        serve(2, 16'h4444, "rr_d");

        // Masking
        do_reset();
        write_mask(16'hFFF7);
        pulse(3);
        cyc();
        bus_if.io_push_ints = 1'b1;
        settle();
        check("mask_pending", d_bus, 16'h0008);
        check("mask_noint", {15'd0, bus_if.io_interrupt}, 16'd0);
        tick();
        bus_if.io_push_ints = 1'b0;
        write_mask(16'hFFFF);
        serve(3, 16'h5555, "mask");

        // No nesting, merged edges
        do_reset();
        pulse(0);
        accept(0, 16'hABCD, "nest");
        pulse(7);
        pulse(7);
        settle();
        check("nest_noint", {15'd0, bus_if.io_interrupt}, 16'd0);
        tick();
        bus_if.io_push_retaddr = 1'b1;
        cyc();
        bus_if.io_push_retaddr = 1'b0;
        serve(7, 16'h0777, "merge");
        for (int i = 0; i < 4; i++) begin
            settle();
            check("merge_once", {15'd0, bus_if.io_interrupt}, 16'd0);
            tick();
        end

        // Set wins over same-cycle clear
        do_reset();
        pulse(4);
        cyc();
        bus_if.irq_in = 16'h0010;
        bus_if.io_store_retaddr = 1'b1;
        cyc();
        bus_if.irq_in = '0;
        bus_if.io_store_retaddr = 1'b0;
        bus_if.io_push_ints = 1'b1;
        settle();
        check("setwins_pending", d_bus, 16'h0010);
        tick();
        bus_if.io_push_ints = 1'b0;
        bus_if.io_push_retaddr = 1'b1;
        cyc();
        bus_if.io_push_retaddr = 1'b0;
        serve(4, 16'h0404, "setwins2");

        // Reset mid-REQ restores the mask
        do_reset();
        pulse(6);
        write_mask(16'h0000);
        do_reset();
        settle();
        check("rstreq_int", {15'd0, bus_if.io_interrupt}, 16'd0);
        check("rstreq_ack", bus_if.irq_ack, 16'd0);
        check("rstreq_bus", d_bus, tb_val);
        tick();
        pulse(9);
        serve(9, 16'h0909, "rstreq_mask");

        // Reset mid-SERVICE clears ret_addr
        pulse(2);
        accept(2, 16'hBEEF, "rstsvc");
        do_reset();
        bus_if.io_push_retaddr = 1'b1;
        settle();
        check("rstsvc_ret", d_bus, 16'h0000);
        check("rstsvc_int", {15'd0, bus_if.io_interrupt}, 16'd0);
        tick();
        bus_if.io_push_retaddr = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus_if.irq_in = 16'($urandom & $urandom & $urandom);
            bus_if.io_store_retaddr = ($urandom_range(0, 4) == 0);
            bus_if.io_push_int_addr = ($urandom_range(0, 7) == 0);
            bus_if.io_push_retaddr  = ($urandom_range(0, 5) == 0);
            bus_if.io_push_ints     = ($urandom_range(0, 7) == 0);
            bus_if.pc_value = 16'($urandom);
            any_push = bus_if.io_push_int_addr || bus_if.io_push_retaddr || bus_if.io_push_ints;
            bus_if.io_write = !any_push && ($urandom_range(0, 9) == 0);
            bus_if.io_addr  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            if (bus_if.io_write) tb_val = 16'($urandom | $urandom);
            cyc();
        end
        rst = 1'b0;
        clr_in();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Round-robin interrupt arbiter and interrupt sequencing slave for the 16-bit CPU. It sits between the IO devices and the control unit. It collects edge-triggered requests from up to 16 sources and raises `io_interrupt` toward the control unit. It then supplies the vector-table address, stores and returns the interrupted PC, and reports pending requests, all under the control unit's `io_*` strobes.

## Interface
Parameters:
- `NUM_SRC`, default 16. Number of request lines, 1..16.
- `VECTOR_BASE`, default 16'h0010. Memory address of vector-table entry 0.
- `MASK_IO_ADDR`, default 4'hF. IO address of the enable-mask register.

Ports:
- `clk` input 1. Single clock; all state updates on posedge.
- `rst` input 1. Synchronous, active-high reset.
- `irq_in` input NUM_SRC. Device request lines; the rising edge is the event.
- `irq_ack` output NUM_SRC. One-cycle pulse on the accepted source.
- `io_interrupt` output 1. Registered; high while a granted request awaits acceptance.
- `io_store_retaddr` input 1. Control unit accepts the interrupt; capture `pc_value`.
- `io_push_int_addr` input 1. Drive the vector address on `d_bus`.
- `io_push_retaddr` input 1. Drive the saved return address on `d_bus`; ends service.
- `io_push_ints` input 1. Drive the pending register (zero-extended) on `d_bus`.
- `io_write` input 1. IO write strobe from the control unit.
- `io_addr` input 4. IO address from the control unit.
- `pc_value` input 16. Current PC, dedicated path. It avoids contention with `pc_push`.
- `d_bus` inout 16. Shared data bus; high-Z unless this block is pushing.

## Operation
- `pending[NUM_SRC-1:0]`: bit set on a rising edge of `irq_in[i]`, using the previous sample in `irq_q`.
  - An edge while the bit is already set merges and is not counted.
- `mask`: written from `d_bus` when `io_write && io_addr==MASK_IO_ADDR`. Bit = 0 excludes the source from arbitration, but pending still records the event.
- Eligible = `pending & mask[NUM_SRC-1:0]`.
- Round-robin search starts at `rr_ptr` and wraps through NUM_SRC-1 to 0. The first eligible index is the winner.
- FSM has three states:
  - IDLE: if any eligible source, latch `grant` = winner and go to REQ.
  - REQ: `io_interrupt`=1 and `grant` is frozen. Mask writes and new edges do not change it.
    - On `io_store_retaddr`: `ret_addr`<=`pc_value`, clear `pending[grant]`, pulse `irq_ack[grant]`, set `rr_ptr`<=(grant+1) mod NUM_SRC, go to SERVICE.
  - SERVICE: no nesting; `io_interrupt`=0. On `io_push_retaddr`, go to IDLE.
- Vector = `VECTOR_BASE + grant`, 16-bit, wraps modulo 2^16.
- `d_bus` drive priority when multiple strobes are high: int_addr, then retaddr, then ints. Otherwise the bus is released to Z.
- Stray strobes:
  - `io_store_retaddr` outside REQ is ignored.
  - `io_push_retaddr` in IDLE or REQ drives `ret_addr` with no state change.
  - `io_push_int_addr` outside REQ/SERVICE drives the vector of the last `grant`.
- Same-cycle clear and new edge on the same source: set wins, and the bit stays pending.

## Timing
- Reset values: `irq_ack`=0, `io_interrupt`=0, `d_bus`=Z, state=IDLE, `pending`=0, `irq_q`=0, `mask`=all ones, `rr_ptr`=0, `grant`=0, `ret_addr`=0.
- Latency: an edge sampled at cycle N sets `pending` at N+1 and drives `io_interrupt`=1 at N+2 from IDLE.
- Acceptance: `io_store_retaddr` at cycle A gives `io_interrupt`=0 and `irq_ack` high at A+1, for exactly one cycle.
- `d_bus` drive is combinational from the push strobes, in the same cycle as the strobe.
- After `io_push_retaddr` at cycle R, the state is IDLE at R+1. The earliest re-assert of `io_interrupt` is R+2.
- `rst` in any state, including REQ and SERVICE, returns to reset values on the next edge. In-flight requests are lost.

## Structure
- Shared CPU package: FSM state encodings (IDLE/REQ/SERVICE) and the default `VECTOR_BASE` / `MASK_IO_ADDR` constants.
- One sub-module, `rr_priority_pick`: combinational round-robin picker. Inputs: eligible vector and start pointer. Outputs: `found` and `index`.

## Test plan
- Single request: pulse `irq_in[3]`. Expect `io_interrupt` 2 cycles later. Strobe `io_push_int_addr` → `d_bus`=16'h0013. Strobe `io_store_retaddr` with `pc_value`=16'h0123 → `irq_ack[3]` one cycle. Strobe `io_push_retaddr` → `d_bus`=16'h0123, then IDLE.
- Round-robin: edges on sources 2 and 5 in the same cycle. Expect grant 2, then 5. Then re-request 2 and 1 with `rr_ptr`=6 → grant 1 before 2.
- Masking: write mask 16'hFFF7, then edge on source 3. Expect `pending`=16'h0008 via `io_push_ints` and `io_interrupt` stays 0. Write 16'hFFFF → interrupt, vector 16'h0013.
- No nesting / merging: during SERVICE, pulse `irq_in[7]` twice. Expect `io_interrupt`=0 until `io_push_retaddr`, then exactly one service of source 7.
- Set-wins: edge on source 4 in the same cycle as acceptance of grant 4. Expect `pending[4]`=1 afterwards and a second interrupt.
- Reset mid-REQ and mid-SERVICE: assert `rst` one cycle. Expect all outputs at reset values, `d_bus`=Z, and `mask`=16'hFFFF.
